instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Streaming RV32I instruction encoder, the inverse of the instruction decoder.
//  Takes instruction fields (format, rd/rs1/rs2, funct3/funct7, imm) and packs them into 32-bit words.
//  Each word is tagged with a sequential instruction-memory address.
//  Used by the boot/program loader and by testbenches to fill instruction memory.
//  Pipelined valid/ready: one register stage, throughput 1 word/cycle.
// PARAMETERS
//  ADDR_W     32            width of out_addr; the address wraps modulo 2^ADDR_W
//  BASE_ADDR  32'h0000_0000 first address emitted after reset or clear
//  ERRCNT_W   8             width of err_count; the count saturates
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  clear      in   1      synchronous; flushes the stage, reloads address, zeroes err_count
//  in_valid   in   1      the input fields are valid
//  in_ready   out  1      the encoder accepts the input this cycle
//  in_fmt     in   4      0 R, 1 I (op-imm), 2 IM (load), 3 S, 4 B, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC; 9-15 illegal
//  in_rd      in   5      destination register
//  in_rs1     in   5      source register 1
//  in_rs2     in   5      source register 2
//  in_funct3  in   3      funct3
//  in_funct7  in   7      funct7; used by R only (I-type shifts carry it in imm[11:5])
//  in_imm     in   32     full signed byte offset / value (U: upper bits, imm[11:0] must be 0)
//  out_valid  out  1      out_instr, out_addr and out_err are valid
//  out_ready  in   1      the consumer accepts the word
//  out_instr  out  32     encoded instruction word
//  out_addr   out  ADDR_W address of this word
//  out_err    out  1      range/alignment/format error on this word
//  err_count  out  ERRCNT_W  number of errored words handed off, saturating
// BEHAVIOUR
//  Reset: out_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR, err_count=0. in_ready=1 after release.
//  Handshake: in_ready = !out_valid | out_ready (combinational).
//   - Accept on in_valid&in_ready. The word registers next cycle (latency 1).
//   - Accept and hand-off may happen in the same cycle, so there are no bubbles.
//   - While out_valid&!out_ready, all out_* stay stable.
//  Opcodes: R 0110011, I 0010011, IM 0000011, S 0100011, B 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
//  Fields: rd->[11:7], funct3->[14:12], rs1->[19:15], rs2->[24:20], funct7->[31:25].
//   - Only fields that the format defines are inserted; all other bits come from imm or are 0.
//   - U/J formats have no funct3/rs1. U/I/J formats have no rs2.
//  Immediates:
//   - I/IM/JALR: [31:20]=imm[11:0]
//   - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
//   - B: {[31],[7],[30:25],[11:8]}={imm[12],imm[11],imm[10:5],imm[4:1]}
//   - JAL: {[31],[19:12],[20],[30:21]}={imm[20],imm[19:12],imm[11],imm[10:1]}
//   - LUI/AUIPC: [31:12]=imm[31:12]
//  Errors (out_err=1; the word is still emitted with the imm bits truncated):
//   - I/IM/JALR/S: imm[31:11] not all equal
//   - B: imm[0]!=0 or imm[31:12] not all equal
//   - JAL: imm[0]!=0 or imm[31:20] not all equal
//   - LUI/AUIPC: imm[11:0]!=0
//   - Illegal fmt: out_instr=32'h0, out_err=1
//  Address: out_addr updates only on an output hand-off (out_valid&out_ready).
//   - The next word then gets the previous address+4; the first word gets BASE_ADDR.
//   - Wraps to 0 modulo 2^ADDR_W, with no flag.
//  err_count: +1 on each hand-off with out_err=1. Holds at 2^ERRCNT_W-1.
//  clear:
//   - Drops any pending word (out_valid=0) and forces in_ready=0 in that cycle.
//   - Address returns to BASE_ADDR; err_count=0.
//   - Takes priority over simultaneous accept/hand-off.
//  Async rst mid-transfer: the pending word is lost; outputs take reset values at once.
// TESTING
//  1 ADDI x1,x0,5 (fmt1,rd1,f3 0,imm 5) -> out_instr 32'h0050_0093, out_addr 0, err 0
//  2 Back-to-back, out_ready=1:
//     - LUI x5,0x12345000 -> 32'h1234_52B7 @4
//     - SW x2,8(x1) -> 32'h0020_A423 @8
//     - BEQ x1,x2,-4 -> 32'hFE20_8EE3 @12
//     - JAL x0,2048 -> 32'h0010_006F @16
//     - in_ready held 1 throughout
//  3 Stall: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_* stable;
//     release -> next word one cycle later, none lost or duplicated
//  4 Errors:
//     - I imm=2048 -> err 1
//     - B imm=3 -> err 1
//     - LUI imm=1 -> err 1
//     - fmt 12 -> instr 0, err 1
//     - result: err_count=4; 300 errored words -> err_count=255
//  5 ADDR_W=4, BASE_ADDR=12: 2 words -> addresses 12, 0 (wrap)
//  6 clear with a word pending -> out_valid=0, next address BASE_ADDR, err_count 0;
//    async rst mid-stall -> out_valid=0 immediately

Source files
------------

// File: rtl/instr_encoder_if.sv
// Valid/ready streaming bus between an instruction-field producer and instr_encoder.
// The producer drives in_* fields, out_ready and clear; the encoder returns words.
interface instr_encoder_if #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned ERRCNT_W = 8
);
   logic                clear;
   logic                in_valid;
   logic                in_ready;
   logic [3:0]          in_fmt;
   logic [4:0]          in_rd;
   logic [4:0]          in_rs1;
   logic [4:0]          in_rs2;
   logic [2:0]          in_funct3;
   logic [6:0]          in_funct7;
   logic [31:0]         in_imm;
   logic                out_valid;
   logic                out_ready;
   logic [31:0]         out_instr;
   logic [ADDR_W-1:0]   out_addr;
   logic                out_err;
   logic [ERRCNT_W-1:0] err_count;

   modport master (
      output clear, in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
      output out_ready,
      input  in_ready, out_valid, out_instr, out_addr, out_err, err_count
   );

   modport slave (
      input  clear, in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
      input  out_ready,
      output in_ready, out_valid, out_instr, out_addr, out_err, err_count
   );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs format/register/immediate fields into 32-bit words,
// one register stage with valid/ready, sequential address tag and saturating error count.
module instr_encoder #(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int unsigned       ERRCNT_W  = 8
) (
   input  logic           clk,
   input  logic           rst,
   instr_encoder_if.slave bus
);
   localparam logic [3:0] FMT_R = 4'd0, FMT_I = 4'd1, FMT_IM = 4'd2, FMT_S = 4'd3,
                          FMT_B = 4'd4, FMT_JAL = 4'd5, FMT_JALR = 4'd6,
                          FMT_LUI = 4'd7, FMT_AUIPC = 4'd8;

   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_IM = 7'b0000011,
                          OP_S = 7'b0100011, OP_B = 7'b1100011, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

   logic [31:0]         w_instr;
   logic                w_err;
   logic                w_accept;
   logic                w_handoff;
   logic                w_imm12_bad;
   logic                w_imm13_bad;
   logic                w_imm21_bad;

   logic                r_vld;
   logic [31:0]         r_instr;
   logic                r_err;
   logic [ADDR_W-1:0]   r_addr;
   logic [ERRCNT_W-1:0] r_errcnt;

   // Range checks: the upper immediate bits must be a pure sign extension of the field.
   assign w_imm12_bad = !((&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]));
   assign w_imm13_bad = !((&bus.in_imm[31:12]) || !(|bus.in_imm[31:12])) || bus.in_imm[0];
   assign w_imm21_bad = !((&bus.in_imm[31:20]) || !(|bus.in_imm[31:20])) || bus.in_imm[0];

   always_comb begin
      w_instr = '0;
      w_err   = 1'b0;
      case (bus.in_fmt)
         FMT_R:
            w_instr = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, OP_R};
         FMT_I: begin
            w_instr = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_I};
            w_err   = w_imm12_bad;
         end
         FMT_IM: begin
            w_instr = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_IM};
            w_err   = w_imm12_bad;
         end
         FMT_JALR: begin
            w_instr = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_JALR};
            w_err   = w_imm12_bad;
         end
         FMT_S: begin
            w_instr = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                       bus.in_imm[4:0], OP_S};
            w_err   = w_imm12_bad;
         end
         FMT_B: begin
            w_instr = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                       bus.in_imm[4:1], bus.in_imm[11], OP_B};
            w_err   = w_imm13_bad;
         end
         FMT_JAL: begin
            w_instr = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                       bus.in_rd, OP_JAL};
            w_err   = w_imm21_bad;
         end
         FMT_LUI: begin
            w_instr = {bus.in_imm[31:12], bus.in_rd, OP_LUI};
            w_err   = |bus.in_imm[11:0];
         end
         FMT_AUIPC: begin
            w_instr = {bus.in_imm[31:12], bus.in_rd, OP_AUIPC};
            w_err   = |bus.in_imm[11:0];
         end
         default: begin
            w_instr = '0;
            w_err   = 1'b1;
         end
      endcase
   end

   // clear blocks acceptance in its cycle so nothing slips in behind the flush.
   assign bus.in_ready = !bus.clear && (!r_vld || bus.out_ready);
   assign w_accept     = bus.in_valid && bus.in_ready;
   assign w_handoff    = r_vld && bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld    <= 1'b0;
         r_instr  <= '0;
         r_err    <= 1'b0;
         r_addr   <= BASE_ADDR;
         r_errcnt <= '0;
      end else if (bus.clear) begin
         r_vld    <= 1'b0;
         r_addr   <= BASE_ADDR;
         r_errcnt <= '0;
      end else begin
         if (w_handoff) begin
            r_addr <= r_addr + ADDR_W'(4);
            if (r_err && (r_errcnt != '1))
               r_errcnt <= r_errcnt + ERRCNT_W'(1);
         end
         if (w_accept) begin
            r_vld   <= 1'b1;
            r_instr <= w_instr;
            r_err   <= w_err;
         end else if (w_handoff) begin
            r_vld <= 1'b0;
         end
      end
   end

   assign bus.out_valid = r_vld;
   assign bus.out_instr = r_instr;
   assign bus.out_err   = r_err;
   assign bus.out_addr  = r_addr;
   assign bus.err_count = r_errcnt;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: vector table streamed back-to-back, then stall,
// saturation, clear, async reset and address-wrap sequences.
module tb_instr_encoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   instr_encoder_if #(.ADDR_W(32), .ERRCNT_W(8)) b1();
   instr_encoder_if #(.ADDR_W(4),  .ERRCNT_W(8)) b2();

   instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .ERRCNT_W(8)) dut (
      .clk(clk), .rst(rst), .bus(b1)
   );
   instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'd12), .ERRCNT_W(8)) dut_wrap (
      .clk(clk), .rst(rst), .bus(b2)
   );

   typedef struct {
      logic [3:0]  fmt;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] exp_instr;
      logic        exp_err;
   } vec_t;

   vec_t vec[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      b1.in_fmt    = v.fmt;
      b1.in_rd     = v.rd;
      b1.in_rs1    = v.rs1;
      b1.in_rs2    = v.rs2;
      b1.in_funct3 = v.f3;
      b1.in_funct7 = v.f7;
      b1.in_imm    = v.imm;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec[0] = '{4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,         32'h0050_0093, 1'b0};
      vec[1] = '{4'd7, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0};
      vec[2] = '{4'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,         32'h0020_A423, 1'b0};
      vec[3] = '{4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4,       32'hFE20_8EE3, 1'b0};
      vec[4] = '{4'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      32'h0010_006F, 1'b0};
      vec[5] = '{4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      32'h8000_0093, 1'b1};
      vec[6] = '{4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,         32'h0020_8163, 1'b1};
      vec[7] = '{4'd7, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1,         32'h0000_02B7, 1'b1};
      vec[8] = '{4'd12, 5'd3, 5'd4, 5'd5, 3'd7, 7'd0, 32'd0,        32'h0000_0000, 1'b1};

      b1.clear = 1'b0; b1.in_valid = 1'b0; b1.out_ready = 1'b0;
      drive(vec[0]);
      b2.clear = 1'b0; b2.in_valid = 1'b0; b2.out_ready = 1'b0;
      b2.in_fmt = 4'd1; b2.in_rd = 5'd1; b2.in_rs1 = 5'd0; b2.in_rs2 = 5'd0;
      b2.in_funct3 = 3'd0; b2.in_funct7 = 7'd0; b2.in_imm = 32'd5;

      #22 rst = 1'b0;
      #1;
      chk("reset out_valid", {31'd0, b1.out_valid}, 32'd0);
      chk("reset out_instr", b1.out_instr, 32'd0);
      chk("reset out_err",   {31'd0, b1.out_err}, 32'd0);
      chk("reset out_addr",  b1.out_addr, 32'd0);
      chk("reset err_count", {24'd0, b1.err_count}, 32'd0);
      chk("reset in_ready",  {31'd0, b1.in_ready}, 32'd1);

      // Address wrap on the 4-bit instance: 12 then 0.
      b2.out_ready = 1'b1; b2.in_valid = 1'b1;
      tick();
      chk("wrap addr0", {28'd0, b2.out_addr}, 32'd12);
      tick();
      chk("wrap addr1", {28'd0, b2.out_addr}, 32'd0);
      chk("wrap valid", {31'd0, b2.out_valid}, 32'd1);
      b2.in_valid = 1'b0;

      // Table streamed back-to-back with the consumer always ready.
      b1.out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         drive(vec[i]);
         b1.in_valid = 1'b1;
         #1;
         chk($sformatf("v%0d in_ready", i), {31'd0, b1.in_ready}, 32'd1);
         tick();
         chk($sformatf("v%0d valid", i), {31'd0, b1.out_valid}, 32'd1);
         chk($sformatf("v%0d instr", i), b1.out_instr, vec[i].exp_instr);
         chk($sformatf("v%0d err", i),   {31'd0, b1.out_err}, {31'd0, vec[i].exp_err});
         chk($sformatf("v%0d addr", i),  b1.out_addr, 32'(4 * i));
      end
      b1.in_valid = 1'b0;
      tick();
      chk("drain valid", {31'd0, b1.out_valid}, 32'd0);
      chk("err_count 4", {24'd0, b1.err_count}, 32'd4);

      // Stall: word A held while word B waits for five cycles.
      b1.out_ready = 1'b0;
      drive(vec[0]);
      b1.in_valid = 1'b1;
      tick();
      drive(vec[1]);
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("stall in_ready", {31'd0, b1.in_ready}, 32'd0);
         tick();
         chk("stall valid", {31'd0, b1.out_valid}, 32'd1);
         chk("stall instr", b1.out_instr, 32'h0050_0093);
         chk("stall addr",  b1.out_addr, 32'd36);
      end
      b1.out_ready = 1'b1;
      tick();
      chk("release instr", b1.out_instr, 32'h1234_52B7);
      chk("release addr",  b1.out_addr, 32'd40);
      b1.in_valid = 1'b0;
      tick();
      chk("release drained", {31'd0, b1.out_valid}, 32'd0);
      chk("release addr next", b1.out_addr, 32'd44);

      // Saturation of the error counter.
      drive(vec[8]);
      b1.in_valid = 1'b1;
      repeat (300) @(posedge clk);
      #1;
      b1.in_valid = 1'b0;
      tick();
      chk("err_count sat", {24'd0, b1.err_count}, 32'd255);

      // clear with a word pending.
      b1.out_ready = 1'b0;
      drive(vec[0]);
      b1.in_valid = 1'b1;
      tick();
      chk("pre-clear valid", {31'd0, b1.out_valid}, 32'd1);
      b1.clear = 1'b1;
      #1;
      chk("clear in_ready", {31'd0, b1.in_ready}, 32'd0);
      tick();
      b1.clear = 1'b0;
      b1.in_valid = 1'b0;
      chk("clear valid", {31'd0, b1.out_valid}, 32'd0);
      chk("clear addr",  b1.out_addr, 32'd0);
      chk("clear err_count", {24'd0, b1.err_count}, 32'd0);
      b1.out_ready = 1'b1;
      drive(vec[2]);
      b1.in_valid = 1'b1;
      tick();
      chk("post-clear instr", b1.out_instr, 32'h0020_A423);
      chk("post-clear addr",  b1.out_addr, 32'd0);
      b1.in_valid = 1'b0;
      tick();

      // Async reset while stalled.
      b1.out_ready = 1'b0;
      drive(vec[1]);
      b1.in_valid = 1'b1;
      tick();
      b1.in_valid = 1'b0;
      chk("pre-rst valid", {31'd0, b1.out_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst valid", {31'd0, b1.out_valid}, 32'd0);
      chk("rst instr", b1.out_instr, 32'd0);
      chk("rst addr",  b1.out_addr, 32'd0);
      #1 rst = 1'b0;
      tick();
      chk("post-rst in_ready", {31'd0, b1.in_ready}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
